// File: rtl/glyph_blitter.sv
// Character-cell renderer: fetches one glyph bitmap from a synchronous ROM and
// streams its pixels into the framebuffer write port, honouring backpressure.
module glyph_blitter #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int GLYPH_W       = 20,
    parameter int GLYPH_H       = 30,
    parameter int ORIGIN_X      = 0,
    parameter int ORIGIN_Y      = 270,
    parameter int CODE_W        = 8,
    parameter int COLOR_W       = 3,
    parameter int ADDR_W        = 19
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       start,
    input  logic [7:0]                 row_num,
    input  logic [7:0]                 col_num,
    input  logic [CODE_W-1:0]          char_code,
    input  logic [COLOR_W-1:0]         fg_color,
    input  logic [COLOR_W-1:0]         bg_color,
    input  logic                       transparent,
    output logic                       ready,
    output logic                       done,
    output logic                       err,
    output logic [CODE_W-1:0]          glyph_addr,
    input  logic [GLYPH_W*GLYPH_H-1:0] glyph_bits,
    output logic [ADDR_W-1:0]          mem_waddr,
    output logic [COLOR_W-1:0]         mem_wdata,
    output logic                       mem_wenable,
    input  logic                       mem_ready
);

    localparam int XW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int YW = (GLYPH_H > 1) ? $clog2(GLYPH_H + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_DRAW, S_DONE} state_t;

    state_t                     r_state, w_next;
    logic [GLYPH_W*GLYPH_H-1:0] r_bits;
    logic [XW-1:0]              r_x;
    logic [YW-1:0]              r_y;
    logic [ADDR_W-1:0]          r_base;
    logic [COLOR_W-1:0]         r_fg, r_bg;
    logic                       r_transp;

    logic [31:0]       w_xend, w_yend;
    logic [ADDR_W-1:0] w_base;
    logic              w_inb, w_accept, w_reject, w_adv, w_last, w_xlast;

    // Cell extents and base address in 32-bit arithmetic, base truncated to ADDR_W.
    assign w_xend = 32'(ORIGIN_X) + (32'(col_num) + 32'd1) * 32'(GLYPH_W);
    assign w_yend = 32'(ORIGIN_Y) + (32'(row_num) + 32'd1) * 32'(GLYPH_H);
    assign w_inb  = (w_xend <= 32'(SCREEN_WIDTH)) && (w_yend <= 32'(SCREEN_HEIGHT));
    assign w_base = ADDR_W'((32'(ORIGIN_Y) + 32'(row_num) * 32'(GLYPH_H)) * 32'(SCREEN_WIDTH)
                            + 32'(ORIGIN_X) + 32'(col_num) * 32'(GLYPH_W));

    assign w_xlast = (r_x == XW'(GLYPH_W - 1));
    assign w_last  = w_xlast && (r_y == YW'(GLYPH_H - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        ready       = 1'b0;
        done        = 1'b0;
        mem_wenable = 1'b0;
        mem_wdata   = '0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if (w_inb) begin
                        w_accept = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_FETCH: w_next = S_LATCH;
            S_LATCH: w_next = S_DRAW;
            S_DRAW: begin
                // Pixel bit is always the LSB of the shifting bitmap.
                mem_wenable = r_bits[0] | ~r_transp;
                mem_wdata   = r_bits[0] ? r_fg : r_bg;
                w_adv       = mem_ready | ~mem_wenable;
                if (w_adv && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err        <= 1'b0;
            glyph_addr <= '0;
            mem_waddr  <= '0;
            r_bits     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_base     <= '0;
            r_fg       <= '0;
            r_bg       <= '0;
            r_transp   <= 1'b0;
        end else begin
            err <= w_reject;
            if (w_accept) begin
                glyph_addr <= char_code;
                r_base     <= w_base;
                r_fg       <= fg_color;
                r_bg       <= bg_color;
                r_transp   <= transparent;
            end
            if (r_state == S_LATCH) begin
                r_bits    <= glyph_bits;
                r_x       <= '0;
                r_y       <= '0;
                mem_waddr <= r_base;
            end
            if (w_adv) begin
                r_bits <= r_bits >> 1;
                if (w_xlast) begin
                    r_x       <= '0;
                    r_y       <= r_y + 1'b1;
                    mem_waddr <= mem_waddr + ADDR_W'(SCREEN_WIDTH - GLYPH_W + 1);
                end else begin
                    r_x       <= r_x + 1'b1;
                    mem_waddr <= mem_waddr + 1'b1;
                end
            end
        end
    end

endmodule
